core_clk_div: RTL and testbench
===============================

Name: core_clk_div

Overview:
- Parametrised multi-channel programmable clock divider; successor to the fixed free-running GPIO prescaler counter.
- Each channel has its own runtime-programmable divisor, enable, single-cycle tick strobe and ~50% duty clock-enable output.
- Sits in wb_gpio; feeds GPIO PWM/timer logic with tick strobes.
- Divisor writes are shadowed and take effect only on a period boundary, so running channels never glitch.

Parameters:
- CHANNELS, 4, number of independent divider channels.
- WIDTH, 16, width of counters and divisors.
- SEL_BITS, 2, width of div_sel; must satisfy 2^SEL_BITS >= CHANNELS.
- DEFAULT_DIV, 16'd15, divisor loaded into every channel at reset (period = DEFAULT_DIV+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  CHANNELS  per-channel run enable.
- sync_restart  in  1  restart all channels in phase.
- div_wr  in  1  divisor write strobe (one cycle).
- div_sel  in  SEL_BITS  channel addressed by div_wr.
- div_data  in  WIDTH  divisor value D; period = D+1 clk cycles.
- tick  out  CHANNELS  registered one-cycle strobe per period.
- clk_out  out  CHANNELS  registered divided clock-enable, ~50% duty.
- pending  out  CHANNELS  shadow divisor waiting to be applied.
- count  out  CHANNELS*WIDTH  live counter values; channel i at [i*WIDTH +: WIDTH].

Behaviour:
- Reset is asynchronous, active-high, clock clk. Reset values: cnt=0, active div=DEFAULT_DIV, shadow=DEFAULT_DIV, pending=0, tick=0, clk_out=0. Reset mid-period aborts immediately.
- Channel running (enable=1): cnt increments 0..D, then wraps to 0. Terminal count is the cycle with cnt==D.
  - tick is registered: high for exactly one cycle, the cycle after terminal count (coincides with cnt==0).
  - clk_out is registered: next value = (cnt_next < ((D+1)>>1)), computed in WIDTH+1 bits so D=2^WIDTH-1 does not overflow.
  - D=0: tick is constant 1 while enabled; clk_out is constant 0.
  - Odd periods: high phase is the shorter one.
- enable=0: cnt held at 0; tick=0; clk_out=0 from the next cycle.
  - On enable 0->1, counting starts from 0. The first tick appears D+1 cycles after enable is first sampled high.
- Divisor write:
  - div_wr=1 loads div_data into the shadow of channel div_sel and sets pending.
  - div_sel >= CHANNELS: write ignored.
  - Shadow is copied to active div and pending clears at the channel's terminal count, or on the next cycle if the channel is disabled.
  - A write while pending=1 overwrites the shadow; the last write wins.
  - A write in the same cycle as terminal count bypasses the shadow and becomes active for the period starting next cycle; pending stays 0.
- sync_restart=1: all enabled channels set cnt=0 next cycle, and every pending shadow is applied at once. No tick is generated for the truncated period.
  - sync_restart has priority over terminal count and over a simultaneous div_wr; the written value is applied as part of the restart.
- Channels are fully independent apart from sync_restart. No combinational path from any input to any output.

Optional Feature:
- Macro CORE_CLK_DIV_ONESHOT_EN.
- Defined: adds input oneshot[CHANNELS] and output done[CHANNELS] (reset 0).
  - A channel with oneshot=1 produces one tick, then sets done=1 and holds cnt=0 and clk_out=0.
  - The channel re-arms only when enable is deasserted, which clears done; counting restarts on re-assertion.
  - sync_restart also clears done.
- Not defined: the ports are absent and all channels free-run. Behaviour is otherwise identical.

Test Plan:
- Reset, then enable[0]=1 with D=15 → first tick 16 cycles after enable; tick repeats every 16 cycles; clk_out high 8 / low 8; count[0] wraps 15→0.
- Channel 1 running with D=9; write D=4 mid-period → pending[1]=1 until terminal count at cnt=9; next period is 5 cycles; pending clears.
- div_wr of D=2 in the exact terminal-count cycle of channel 2 → next period is 3 cycles; pending[2] never asserts.
- Channels 0..3 with D=3,5,7,0 running; pulse sync_restart → all counts read 0 the following cycle; no tick from the truncated period; D=0 channel ticks every cycle with clk_out=0.
- div_sel=3 with CHANNELS=3, div_wr=1 → no pending bit changes, all periods unchanged. Assert rst mid-period → all outputs 0 and div reverts to 15.
- CORE_CLK_DIV_ONESHOT_EN, oneshot[0]=1, D=7 → single tick 8 cycles after enable, done[0]=1, no further ticks; toggle enable 1→0→1 → done clears, next single tick 8 cycles later.

Source files
------------

// File: rtl/core_clk_div.sv
// Multi-channel programmable clock divider with shadowed, glitch-free divisor updates.
// Defining CORE_CLK_DIV_ONESHOT_EN adds per-channel one-shot mode (oneshot_i / done_o).
module core_clk_div #(
  parameter int unsigned      CHANNELS    = 4,
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      SEL_BITS    = 2,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(15)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic                      sync_restart_i,
  input  logic                      div_wr_i,
  input  logic [SEL_BITS-1:0]       div_sel_i,
  input  logic [WIDTH-1:0]          div_data_i,
`ifdef CORE_CLK_DIV_ONESHOT_EN
  input  logic [CHANNELS-1:0]       oneshot_i,
  output logic [CHANNELS-1:0]       done_o,
`endif
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       clk_out_o,
  output logic [CHANNELS-1:0]       pending_o,
  output logic [CHANNELS*WIDTH-1:0] count_o
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, shd_q, shd_d;
    logic             pend_q, pend_d, tick_q, tick_d, cko_q, cko_d, done_q, done_d;
    logic             wr_hit, cko_en, oneshot;
    logic [WIDTH:0]   half;

`ifdef CORE_CLK_DIV_ONESHOT_EN
    assign oneshot   = oneshot_i[i];
    assign done_o[i] = done_q;
`else
    assign oneshot   = 1'b0;
`endif

    assign wr_hit = div_wr_i && (div_sel_i == SEL_BITS'(i));

    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      done_d = done_q;
      tick_d = 1'b0;
      cko_en = 1'b0;
      if (sync_restart_i) begin
        // Restart wins over terminal count; a same-cycle write is folded into the restart.
        cnt_d  = '0;
        pend_d = 1'b0;
        done_d = 1'b0;
        cko_en = enable_i[i];
        if (wr_hit) begin
          shd_d = div_data_i;
          div_d = div_data_i;
        end else if (pend_q) begin
          div_d = shd_q;
        end
      end else if (!enable_i[i] || done_q) begin
        cnt_d = '0;
        if (!enable_i[i]) done_d = 1'b0;
        if (pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
        if (wr_hit) begin
          shd_d  = div_data_i;
          pend_d = 1'b1;
        end
      end else if (cnt_q == div_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (wr_hit) begin
          div_d  = div_data_i;
          shd_d  = div_data_i;
          pend_d = 1'b0;
        end else if (pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
        if (oneshot) done_d = 1'b1;
        else         cko_en = 1'b1;
      end else begin
        cnt_d  = cnt_q + WIDTH'(1);
        cko_en = 1'b1;
        if (wr_hit) begin
          shd_d  = div_data_i;
          pend_d = 1'b1;
        end
      end
    end

    // One extra bit so D = 2^WIDTH-1 does not wrap when forming (D+1)/2.
    assign half  = ({1'b0, div_d} + (WIDTH+1)'(1)) >> 1;
    assign cko_d = cko_en && ({1'b0, cnt_d} < half);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        div_q  <= DEFAULT_DIV;
        shd_q  <= DEFAULT_DIV;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        cko_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        cko_q  <= cko_d;
        done_q <= done_d;
      end
    end

    assign tick_o[i]                  = tick_q;
    assign clk_out_o[i]               = cko_q;
    assign pending_o[i]               = pend_q;
    assign count_o[i*WIDTH +: WIDTH]  = cnt_q;
  end

endmodule

// File: tb/tb_core_clk_div.sv
// Scoreboard bench for core_clk_div: a 4-channel/16-bit instance and a 3-channel/4-bit
// instance share stimulus and are checked against one behavioural divider model.
module tb_core_clk_div;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int N3 = 3;
  localparam int W3 = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   enable = '0;
  logic [N-1:0]   oneshot = '0;
  logic           sync_restart = 1'b0;
  logic           div_wr = 1'b0;
  logic [1:0]     div_sel = '0;
  logic [W-1:0]   div_data = '0;
  logic [N-1:0]   tick, clk_out, pending, done;
  logic [N*W-1:0] count;
  logic [N3-1:0]  tick3, clk_out3, pending3, done3;
  logic [N3*W3-1:0] count3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_clk_div #(.CHANNELS(N), .WIDTH(W), .SEL_BITS(2), .DEFAULT_DIV(16'd15)) u_dut (
    .clk(clk), .rst(rst), .enable_i(enable), .sync_restart_i(sync_restart),
    .div_wr_i(div_wr), .div_sel_i(div_sel), .div_data_i(div_data),
`ifdef CORE_CLK_DIV_ONESHOT_EN
    .oneshot_i(oneshot), .done_o(done),
`endif
    .tick_o(tick), .clk_out_o(clk_out), .pending_o(pending), .count_o(count)
  );

  core_clk_div #(.CHANNELS(N3), .WIDTH(W3), .SEL_BITS(2), .DEFAULT_DIV(4'd15)) u_dut3 (
    .clk(clk), .rst(rst), .enable_i(enable[N3-1:0]), .sync_restart_i(sync_restart),
    .div_wr_i(div_wr), .div_sel_i(div_sel), .div_data_i(div_data[W3-1:0]),
`ifdef CORE_CLK_DIV_ONESHOT_EN
    .oneshot_i(oneshot[N3-1:0]), .done_o(done3),
`endif
    .tick_o(tick3), .clk_out_o(clk_out3), .pending_o(pending3), .count_o(count3)
  );

`ifndef CORE_CLK_DIV_ONESHOT_EN
  assign done  = '0;
  assign done3 = '0;
`endif

  // Reference model: per-channel position within the current period.
  int m_div[N], m_shd[N], m_cnt[N];
  bit m_pend[N], m_tick[N], m_cko[N], m_done[N];

  typedef struct packed {
    logic [N-1:0]   tick;
    logic [N-1:0]   cko;
    logic [N-1:0]   pend;
    logic [N-1:0]   done;
    logic [N*W-1:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_div[i] = 15; m_shd[i] = 15; m_cnt[i] = 0;
      m_pend[i] = 0; m_tick[i] = 0; m_cko[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step();
    bit wr, wrap;
    int d, period;
    for (int i = 0; i < N; i++) begin
      wr = div_wr && (int'(div_sel) == i);
      d  = int'(div_data);
      if (sync_restart) begin
        if (wr) begin m_shd[i] = d; m_div[i] = d; end
        else if (m_pend[i]) m_div[i] = m_shd[i];
        m_pend[i] = 0; m_done[i] = 0; m_cnt[i] = 0; m_tick[i] = 0;
        m_cko[i] = enable[i] && ((m_div[i] + 1) / 2 > 0);
      end else if (!enable[i] || m_done[i]) begin
        if (!enable[i]) m_done[i] = 0;
        if (m_pend[i]) begin m_div[i] = m_shd[i]; m_pend[i] = 0; end
        if (wr) begin m_shd[i] = d; m_pend[i] = 1; end
        m_cnt[i] = 0; m_tick[i] = 0; m_cko[i] = 0;
      end else begin
        period    = m_div[i] + 1;
        wrap      = (m_cnt[i] + 1 == period);
        m_cnt[i]  = (m_cnt[i] + 1) % period;
        m_tick[i] = wrap;
        if (wrap) begin
          if (wr) begin m_div[i] = d; m_shd[i] = d; m_pend[i] = 0; end
          else if (m_pend[i]) begin m_div[i] = m_shd[i]; m_pend[i] = 0; end
          if (oneshot[i]) m_done[i] = 1;
        end else if (wr) begin
          m_shd[i] = d; m_pend[i] = 1;
        end
        m_cko[i] = !m_done[i] && (m_cnt[i] < (m_div[i] + 1) / 2);
      end
    end
  endtask

  task automatic push_exp();
    exp_t x;
    for (int i = 0; i < N; i++) begin
      x.tick[i] = m_tick[i];
      x.cko[i]  = m_cko[i];
      x.pend[i] = m_pend[i];
      x.done[i] = m_done[i];
      x.cnt[i*W +: W] = W'(m_cnt[i]);
    end
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle; compare one hair after the edge.
  initial begin
    logic [N3*W3-1:0] c3;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tick", 64'(tick), 64'(e.tick));
        chk("clk_out", 64'(clk_out), 64'(e.cko));
        chk("pending", 64'(pending), 64'(e.pend));
        chk("done", 64'(done), 64'(e.done));
        chk("count", 64'(count), 64'(e.cnt));
        for (int i = 0; i < N3; i++) c3[i*W3 +: W3] = e.cnt[i*W +: W3];
        chk("tick3", 64'(tick3), 64'(e.tick[N3-1:0]));
        chk("clk_out3", 64'(clk_out3), 64'(e.cko[N3-1:0]));
        chk("pending3", 64'(pending3), 64'(e.pend[N3-1:0]));
        chk("done3", 64'(done3), 64'(e.done[N3-1:0]));
        chk("count3", 64'(count3), 64'(c3));
      end
    end
  end

  task automatic cycle();
    model_step();
    push_exp();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic write(input int sel, input int data);
    div_wr   = 1'b1;
    div_sel  = 2'(sel);
    div_data = 16'(data);
    cycle();
    div_wr   = 1'b0;
  endtask

  // Cycles until the next tick on channel ch, bounded.
  task automatic tick_gap(input int ch, input int want, input string name);
    int  k;
    bit  seen;
    k = 0;
    seen = 0;
    while (!seen && k < 64) begin
      cycle();
      k++;
      seen = tick[ch];
    end
    chk(name, 64'(k), 64'(want));
  endtask

  initial begin
    int k, hi, nt;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {tick, clk_out, pending, done}, 64'h0);
    chk("reset_count", 64'(count), 64'h0);
    model_reset();
    rst = 1'b0;

    // Default divisor 15: period 16, 8 high / 8 low.
    enable[0] = 1'b1;
    tick_gap(0, 16, "first_tick");
    tick_gap(0, 16, "tick_period");
    hi = 0;
    for (int c = 0; c < 16; c++) begin cycle(); hi += int'(clk_out[0]); end
    chk("clk_out_duty", 64'(hi), 64'd8);

    // Channel 1: D=9, rewritten to 4 mid-period.
    write(1, 9);
    run(1);
    enable[1] = 1'b1;
    run(4);
    write(1, 4);
    chk("pend1_set", 64'(pending[1]), 64'd1);
    tick_gap(1, 5, "tick_after_write");
    chk("pend1_clear", 64'(pending[1]), 64'd0);
    tick_gap(1, 5, "short_period");

    // Channel 2: write lands exactly on terminal count.
    write(2, 6);
    run(1);
    enable[2] = 1'b1;
    k = 0;
    while (m_cnt[2] != m_div[2] && k < 40) begin cycle(); k++; end
    chk("tc_reached", 64'(m_cnt[2] == m_div[2]), 64'd1);
    write(2, 2);
    chk("pend2_bypass", 64'(pending[2]), 64'd0);
    tick_gap(2, 3, "bypass_period");

    // All channels with D=3,5,7,0, then an in-phase restart.
    write(0, 3); write(1, 5); write(2, 7); write(3, 0);
    enable = 4'hf;
    run(30);
    sync_restart = 1'b1;
    cycle();
    sync_restart = 1'b0;
    chk("sync_count", 64'(count), 64'h0);
    chk("sync_no_tick", 64'(tick), 64'h0);
    run(1);
    chk("d0_tick", 64'(tick[3]), 64'd1);
    chk("d0_clk_out", 64'(clk_out[3]), 64'd0);
    run(20);

    // Out-of-range select on the 3-channel instance.
    write(3, 9);
    chk("sel3_ignored", 64'(pending3), 64'h0);
    run(20);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 49) == 0) enable[i] = ~enable[i];
`ifdef CORE_CLK_DIV_ONESHOT_EN
      for (int i = 0; i < N; i++) if ($urandom_range(0, 99) == 0) oneshot[i] = ~oneshot[i];
`endif
      sync_restart = ($urandom_range(0, 59) == 0);
      div_wr       = ($urandom_range(0, 7) == 0);
      div_sel      = 2'($urandom_range(0, 3));
      div_data     = 16'($urandom_range(0, 15));
      cycle();
    end
    sync_restart = 1'b0;
    div_wr = 1'b0;
    oneshot = '0;

    // Asynchronous reset in the middle of a period.
    enable = 4'hf;
    run(7);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {tick, clk_out, pending, done}, 64'h0);
    chk("rst_async_count", 64'(count), 64'h0);
    model_reset();
    enable = '0;
    @(negedge clk);
    rst = 1'b0;
    enable[0] = 1'b1;
    tick_gap(0, 16, "post_reset_div");

`ifdef CORE_CLK_DIV_ONESHOT_EN
    enable = '0;
    oneshot[0] = 1'b1;
    write(0, 7);
    run(2);
    enable[0] = 1'b1;
    tick_gap(0, 8, "oneshot_tick");
    chk("oneshot_done", 64'(done[0]), 64'd1);
    nt = 0;
    for (int c = 0; c < 20; c++) begin cycle(); nt += int'(tick[0]); end
    chk("oneshot_no_more", 64'(nt), 64'd0);
    enable[0] = 1'b0;
    cycle();
    chk("oneshot_rearm", 64'(done[0]), 64'd0);
    enable[0] = 1'b1;
    tick_gap(0, 8, "oneshot_second");
    oneshot = '0;
`endif

    run(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
